mcycle_ctrl: RTL

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

---
 rtl/mcycle_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mcycle_ctrl.sv
// Multicycle MIPS-subset control unit: Moore FSM with byte-wise instruction fetch
// plus a combinational PC enable so a taken beq updates the PC in BEQEX.
module mcycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memwrite,
    output logic       alusrca,
    output logic       memtoreg,
    output logic       regdst,
    output logic       iord,
    output logic       regwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic [1:0] alusrcb,
    output logic [3:0] irwrite,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12,
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14
    } state_e;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_e state_q;
    state_e state_d;
    logic   pcwrite;
    logic   branch;

    // State register; reset forces FETCH1 without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH1;
        case (state_q)
            FETCH1:  state_d = FETCH2;
            FETCH2:  state_d = FETCH3;
            FETCH3:  state_d = FETCH4;
            FETCH4:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
                    OP_ADDI:      state_d = ADDIEX;
                    default:      state_d = FETCH1;
                endcase
            end
            MEMADR: begin
                if (op == OP_LB) begin
                    state_d = LBRD;
                end else if (op == OP_SB) begin
                    state_d = SBWR;
                end else begin
                    state_d = FETCH1;
                end
            end
            LBRD:    state_d = LBWR;
            RTYPEEX: state_d = RTYPEWR;
            ADDIEX:  state_d = ADDIWR;
            default: state_d = FETCH1;
        endcase
    end

    // Moore output decode; anything a state does not drive stays 0.
    always_comb begin
        memwrite   = 1'b0;
        alusrca    = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        iord       = 1'b0;
        regwrite   = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        pcsrc      = 2'b00;
        alusrcb    = 2'b00;
        irwrite    = 4'b0000;
        alucontrol = 3'b000;
        case (state_q)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                irwrite    = 4'(4'b0001 << state_q[1:0]);
                alusrcb    = 2'b01;
                pcwrite    = 1'b1;
                alucontrol = ALU_ADD;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
            end
            MEMADR, ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            LBRD: iord = 1'b1;
            LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            SBWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            RTYPEWR: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                branch     = 1'b1;
                pcsrc      = 2'b01;
            end
            JEX: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
            ADDIWR: regwrite = 1'b1;
            default: ;
        endcase
    end

    // Branch resolves in BEQEX itself, so zero feeds pcen combinationally.
    assign pcen  = pcwrite | (branch & zero);
    assign state = state_q;

endmodule
